// File: rtl/bin_to_bcd_if.sv
// Handshake and result bundle between a binary value producer and the BCD converter.
interface bin_to_bcd_if #(
    parameter int unsigned IN_WIDTH = 20,
    parameter int unsigned DIGITS   = 6
);
    logic                  start;
    logic [IN_WIDTH-1:0]   bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]     lz_mask;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, lz_mask, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, lz_mask, overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one adjust+shift step per clock, saturating to all 9s on
// overflow, with a leading-zero mask for blanking unused high display digits.
module bin_to_bcd_seq #(
    parameter int unsigned IN_WIDTH = 20,
    parameter int unsigned DIGITS   = 6
) (
    input logic          clk,
    input logic          rst,
    bin_to_bcd_if.slave  io_bus
);
    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(IN_WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StConvert} state_e;

    state_e              r_state, w_state_d;
    logic [IN_WIDTH-1:0] r_bin, w_bin_d;
    logic [BcdW-1:0]     r_scratch, w_scratch_d, w_adj;
    logic [CntW-1:0]     r_cnt, w_cnt_d;
    logic                r_sticky, w_sticky_d;
    logic [BcdW-1:0]     r_bcd, w_bcd_d;
    logic [DIGITS-1:0]   r_lz, w_lz_d, w_lz_calc;
    logic                r_ovf, w_ovf_d;
    logic                r_done, w_done_d;
    logic                w_zero_run;

    // All digits are adjusted in parallel from their pre-adjust values.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_bin_d     = r_bin;
        w_scratch_d = r_scratch;
        w_cnt_d     = r_cnt;
        w_sticky_d  = r_sticky;
        w_bcd_d     = r_bcd;
        w_ovf_d     = r_ovf;
        w_done_d    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (io_bus.start) begin
                    w_bin_d     = io_bus.bin_in;
                    w_scratch_d = '0;
                    w_cnt_d     = CntW'(IN_WIDTH);
                    w_sticky_d  = 1'b0;
                    w_state_d   = StConvert;
                end
            end
            StConvert: begin
                w_scratch_d = {w_adj[BcdW-2:0], r_bin[IN_WIDTH-1]};
                w_bin_d     = {r_bin[IN_WIDTH-2:0], 1'b0};
                w_sticky_d  = r_sticky | w_adj[BcdW-1];
                w_cnt_d     = r_cnt - 1'b1;
                if (r_cnt == CntW'(1)) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                    w_ovf_d   = w_sticky_d;
                    w_bcd_d   = w_sticky_d ? {DIGITS{4'h9}} : w_scratch_d;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Bit i marks digit i as leading zero when it and every digit above it are zero.
    always_comb begin
        w_zero_run = 1'b1;
        w_lz_calc  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run   = w_zero_run & (w_bcd_d[4*i +: 4] == 4'd0);
            w_lz_calc[i] = w_zero_run;
        end
        w_lz_d = w_done_d ? w_lz_calc : r_lz;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_sticky  <= 1'b0;
            r_bcd     <= '0;
            r_lz      <= {{(DIGITS-1){1'b1}}, 1'b0};
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_bin     <= w_bin_d;
            r_scratch <= w_scratch_d;
            r_cnt     <= w_cnt_d;
            r_sticky  <= w_sticky_d;
            r_bcd     <= w_bcd_d;
            r_lz      <= w_lz_d;
            r_ovf     <= w_ovf_d;
            r_done    <= w_done_d;
        end
    end

    assign io_bus.busy     = (r_state == StConvert);
    assign io_bus.done     = r_done;
    assign io_bus.bcd_out  = r_bcd;
    assign io_bus.lz_mask  = r_lz;
    assign io_bus.overflow = r_ovf;
endmodule
